icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache and refill controller between the IF stage and the block-wide instruction memory. It serves one or two sequential instruction words per cycle on a hit. On a miss it stalls IF, fetches a 256-bit line over the iBlkRead handshake, installs the line, and replays the fetch. It replaces the direct Instr1_fIM/Instr2_fIM path from memory into the pipeline.

## Interface
- LINES, 16, number of cache lines; power of two, ≥2; index width IW = log2(LINES)
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- Instr_address_2IM  in  32  fetch address from IF; bits [1:0] ignored
- fetch_req  in  1  IF requests a fetch this cycle
- flush  in  1  invalidate all lines
- Instr1_fIM  out  32  word at fetch address
- Instr2_fIM  out  32  word at fetch address + 4
- instr2_valid  out  1  Instr2_fIM usable; 0 when the fetch word offset is 7
- icache_stall  out  1  IF must freeze and hold Instr_address_2IM
- iBlkRead  out  1  line refill request to instruction memory
- block_address_2IM  out  32  line-aligned refill address, low 5 bits zero
- block_read_fIM  in  256  refill line; word i at bits [32i+31:32i]
- block_ready_fIM  in  1  one-cycle strobe; block_read_fIM valid this cycle

## Operation
- Address split:
  - offset = addr[4:2]
  - index = addr[5+IW-1:5]
  - tag = addr[31:5+IW]
- Per line storage: valid bit, tag, and 8×32 data, all in flops.
- Hit = fetch_req & valid[index] & (tag match). Lookup is combinational.
- Hit outputs:
  - Instr1_fIM = data[index][offset]
  - Instr2_fIM = data[index][offset+1]
  - instr2_valid = (offset != 7)
- If no hit, or not in IDLE: Instr1_fIM = Instr2_fIM = 0 (NOP) and instr2_valid = 0.
- icache_stall = fetch_req & ~hit in IDLE; stall is 1 in REFILL and in REPLAY.
- FSM states:
  - IDLE: on fetch_req & miss (and no flush), latch the miss address and go to REFILL.
  - REFILL: iBlkRead = 1; block_address_2IM = {latched addr[31:5], 5'b0}. Hold both stable until block_ready_fIM. On the strobe, write data and tag, set valid (unless a flush is pending), then go to REPLAY.
  - REPLAY: one cycle, stall held. Go to IDLE; the next cycle's lookup hits.
- Flush:
  - In IDLE, flush clears all valid bits at the edge. Output that cycle is a miss/stall with no refill started.
  - During REFILL or REPLAY, flush sets flush_pending. The line is written but its valid bit stays clear, and all other valids are cleared at the strobe. flush_pending clears on return to IDLE.
- fetch_req = 0 in IDLE: no stall, outputs 0, no state change.
- Address change while stalled is illegal. The controller uses the latched address and does not check.
- block_ready_fIM outside REFILL is ignored.

## Timing
- Reset: state IDLE, all valid = 0, flush_pending = 0. All outputs are 0: iBlkRead = 0, block_address_2IM = 0, icache_stall = 0 until a fetch_req arrives.
- Reset asserted mid-refill drops iBlkRead immediately (async). The line is not installed.
- Hit latency: 0 cycles (combinational, same cycle as fetch_req).
- Miss penalty: N + 2 cycles of icache_stall, where N is the number of REFILL cycles up to and including the block_ready_fIM cycle.
  - Cycle 0: miss detected, stall = 1.
  - Cycles 1..N: REFILL.
  - Cycle N+1: REPLAY.
  - Cycle N+2: hit, stall = 0.
- iBlkRead is registered: it rises the cycle after the miss and falls the cycle after block_ready_fIM.
- Data written on the block_ready_fIM edge is visible to a lookup in the next cycle.

## Test plan
- Cold miss:
  - Stimulus: reset, fetch_req = 1 at 0x0000_0040. block_ready_fIM comes 3 cycles after iBlkRead with a line whose word i = 0x1000_0000 + i.
  - Required: block_address_2IM = 0x0000_0040; stall = 1 for 5 cycles. Then Instr1 = 0x1000_0000, Instr2 = 0x1000_0001, instr2_valid = 1.
- Line-end pair:
  - Stimulus: after the previous scenario, fetch 0x0000_005C.
  - Required: hit, stall = 0, Instr1 = 0x1000_0007, instr2_valid = 0.
- Conflict eviction (LINES = 16):
  - Stimulus: fetch 0x0000_0240, which has the same index as 0x40 and a different tag. After that refill completes, fetch 0x40 again.
  - Required: both fetches miss, and iBlkRead is issued twice.
- Flush during refill:
  - Stimulus: assert flush in the second REFILL cycle of a miss to 0x80.
  - Required: the replayed fetch still completes. The next fetch of 0x80 misses again, and a fetch of a previously resident line also misses.
- Reset mid-refill:
  - Stimulus: assert RESET while iBlkRead = 1, deassert it, then fetch the same address.
  - Required: iBlkRead = 0 during reset, a fresh miss/refill follows, and a stray block_ready_fIM pulse in IDLE changes nothing.
- Idle behaviour:
  - Stimulus: fetch_req = 0 for 10 cycles after reset.
  - Required: icache_stall = 0, iBlkRead = 0, and Instr1_fIM = 0 throughout.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with line refill controller between IF and instruction memory.
// Serves up to two sequential words per cycle on a hit; stalls IF while a 256-bit line is fetched.
module icache_ctrl #(
    parameter int unsigned LINES = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  Instr_address_2IM,
    input  logic         fetch_req,
    input  logic         flush,
    output logic [31:0]  Instr1_fIM,
    output logic [31:0]  Instr2_fIM,
    output logic         instr2_valid,
    output logic         icache_stall,
    output logic         iBlkRead,
    output logic [31:0]  block_address_2IM,
    input  logic [255:0] block_read_fIM,
    input  logic         block_ready_fIM
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 32 - 5 - IW;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        REPLAY
    } state_t;

    state_t              state_q, state_next;
    logic [LINES-1:0]    valid_q;
    logic [TW-1:0]       tag_q  [LINES];
    logic [7:0][31:0]    data_q [LINES];
    logic [26:0]         miss_line_q;
    logic                flush_pending_q;
    logic                hit;

    logic [2:0]          off;
    logic [IW-1:0]       idx;
    logic [TW-1:0]       tag;
    logic [IW-1:0]       refill_idx;
    logic [TW-1:0]       refill_tag;
    logic                unused_addr_bits;

    assign off              = Instr_address_2IM[4:2];
    assign idx              = Instr_address_2IM[5+IW-1:5];
    assign tag              = Instr_address_2IM[31:5+IW];
    assign refill_idx       = miss_line_q[IW-1:0];
    assign refill_tag       = miss_line_q[26:IW];
    assign unused_addr_bits = ^Instr_address_2IM[1:0];

    // Combinational lookup, fetch outputs and next-state
    always_comb begin
        state_next   = state_q;
        Instr1_fIM   = '0;
        Instr2_fIM   = '0;
        instr2_valid = 1'b0;
        icache_stall = 1'b0;
        hit          = (state_q == IDLE) & fetch_req & ~flush & valid_q[idx] & (tag_q[idx] == tag);

        if (hit) begin
            Instr1_fIM   = data_q[idx][off];
            Instr2_fIM   = data_q[idx][off + 3'd1];
            instr2_valid = (off != 3'd7);
        end

        case (state_q)
            IDLE: begin
                icache_stall = fetch_req & ~hit;
                if (fetch_req & ~hit & ~flush) state_next = REFILL;
            end
            REFILL: begin
                icache_stall = 1'b1;
                if (block_ready_fIM) state_next = REPLAY;
            end
            REPLAY: begin
                icache_stall = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, refill request and valid bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q           <= IDLE;
            iBlkRead          <= 1'b0;
            block_address_2IM <= '0;
            miss_line_q       <= '0;
            flush_pending_q   <= 1'b0;
            valid_q           <= '0;
        end else begin
            state_q         <= state_next;
            iBlkRead        <= (state_next == REFILL);
            flush_pending_q <= (state_next != IDLE) &
                               (flush_pending_q | (flush & (state_q != IDLE)));

            if ((state_q == IDLE) && (state_next == REFILL)) begin
                miss_line_q       <= Instr_address_2IM[31:5];
                block_address_2IM <= {Instr_address_2IM[31:5], 5'b0};
            end

            // A flush seen anywhere during the miss leaves the new line invalid too
            case (state_q)
                IDLE: begin
                    if (flush) valid_q <= '0;
                end
                REFILL: begin
                    if (block_ready_fIM) begin
                        if (flush_pending_q | flush) valid_q <= '0;
                        else                         valid_q[refill_idx] <= 1'b1;
                    end
                end
                REPLAY: begin
                    if (flush) valid_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Line storage needs no reset; valid bits gate every use
    always_ff @(posedge CLK) begin
        if ((state_q == REFILL) && block_ready_fIM) begin
            data_q[refill_idx] <= block_read_fIM;
            tag_q[refill_idx]  <= refill_tag;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: table of sequential fetches plus hand-built
// flush, reset and idle sequences; fetched words are checked through a scoreboard queue.
module tb_icache_ctrl;

    logic         CLK;
    logic         RESET;
    logic [31:0]  Instr_address_2IM;
    logic         fetch_req;
    logic         flush;
    logic [31:0]  Instr1_fIM;
    logic [31:0]  Instr2_fIM;
    logic         instr2_valid;
    logic         icache_stall;
    logic         iBlkRead;
    logic [31:0]  block_address_2IM;
    logic [255:0] block_read_fIM;
    logic         block_ready_fIM;

    icache_ctrl #(.LINES(16)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr_address_2IM (Instr_address_2IM),
        .fetch_req         (fetch_req),
        .flush             (flush),
        .Instr1_fIM        (Instr1_fIM),
        .Instr2_fIM        (Instr2_fIM),
        .instr2_valid      (instr2_valid),
        .icache_stall      (icache_stall),
        .iBlkRead          (iBlkRead),
        .block_address_2IM (block_address_2IM),
        .block_read_fIM    (block_read_fIM),
        .block_ready_fIM   (block_ready_fIM)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] addr;
        int          stalls;
        int          reads;
    } vec_t;

    typedef struct {
        logic [31:0] i1;
        logic [31:0] i2;
        logic        i2v;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          nreads   = 0;
    int          rd_cnt   = 0;
    int          mem_lat  = 3;
    bit          mem_en   = 1'b1;
    bit          blk_prev = 1'b0;
    logic [31:0] exp_blk_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
        return 32'h1000_0000 + ((line - 32'h40) << 3) + 32'(i);
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] line);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(line, i);
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, act as instruction memory, then check refill address and scoreboard
    task automatic tick(input bit fr, input logic [31:0] a, input bit fl, input bit stray);
        @(posedge CLK);
        #1;
        fetch_req         = fr;
        Instr_address_2IM = a;
        flush             = fl;
        if (stray) begin
            block_ready_fIM = 1'b1;
            block_read_fIM  = {8{32'hDEAD_BEEF}};
        end else if (mem_en && iBlkRead) begin
            rd_cnt++;
            if (rd_cnt == mem_lat) begin
                block_ready_fIM = 1'b1;
                block_read_fIM  = line_of(block_address_2IM);
                rd_cnt          = 0;
            end else begin
                block_ready_fIM = 1'b0;
            end
        end else begin
            block_ready_fIM = 1'b0;
            rd_cnt          = 0;
        end
        #1;
        if (iBlkRead && !blk_prev) begin
            nreads++;
            check("block_address", block_address_2IM, exp_blk_addr);
        end
        blk_prev = iBlkRead;
        if (fetch_req && !icache_stall) begin
            if (sb.size() == 0) begin
                check("unexpected_hit", 32'(fetch_req), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("instr1", Instr1_fIM, e.i1);
                if (e.i2v) check("instr2", Instr2_fIM, e.i2);
                check("instr2_valid", 32'(instr2_valid), 32'(e.i2v));
            end
        end
    endtask

    // Hold a fetch until served; compare stall cycles and refill count
    task automatic fetch(input logic [31:0] a, input int exp_stalls, input int exp_reads);
        int   stalls;
        int   reads0;
        bit   done;
        exp_t e;
        logic [31:0] line;
        logic [2:0]  o;
        stalls = 0;
        reads0 = nreads;
        done   = 1'b0;
        line   = a & ~32'h1F;
        o      = a[4:2];
        exp_blk_addr = line;
        e.i1  = mem_word(line, int'(o));
        e.i2  = mem_word(line, int'(o) + 1);
        e.i2v = (o != 3'd7);
        sb.push_back(e);
        for (int c = 0; c < 40 && !done; c++) begin
            tick(1'b1, a, 1'b0, 1'b0);
            if (icache_stall) stalls++;
            else              done = 1'b1;
        end
        check($sformatf("served_%h", a), 32'(done), 32'd1);
        check($sformatf("stalls_%h", a), 32'(stalls), 32'(exp_stalls));
        check($sformatf("reads_%h", a), 32'(nreads - reads0), 32'(exp_reads));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0040, 5, 1};
        vecs[1] = '{32'h0000_005C, 0, 0};
        vecs[2] = '{32'h0000_0048, 0, 0};
        vecs[3] = '{32'h0000_0240, 5, 1};
        vecs[4] = '{32'h0000_0040, 5, 1};
        vecs[5] = '{32'h0000_0044, 0, 0};
        vecs[6] = '{32'h0000_00C0, 5, 1};
        vecs[7] = '{32'h0000_00DC, 0, 0};
        vecs[8] = '{32'h0000_005C, 0, 0};

        RESET             = 1'b1;
        fetch_req         = 1'b0;
        flush             = 1'b0;
        Instr_address_2IM = '0;
        block_read_fIM    = '0;
        block_ready_fIM   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_iBlkRead", 32'(iBlkRead), 32'd0);
        check("rst_block_address", block_address_2IM, 32'd0);
        check("rst_stall", 32'(icache_stall), 32'd0);
        #2 RESET = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 32'h0000_0040, 1'b0, 1'b0);
            check("idle_stall", 32'(icache_stall), 32'd0);
            check("idle_iBlkRead", 32'(iBlkRead), 32'd0);
            check("idle_instr1", Instr1_fIM, 32'd0);
        end

        // Cold miss, line-end pair, conflict eviction and further hits
        for (int i = 0; i < 9; i++) fetch(vecs[i].addr, vecs[i].stalls, vecs[i].reads);
        tick(1'b0, '0, 1'b0, 1'b0);

        // Flush in the second refill cycle of a miss to 0x80
        exp_blk_addr = 32'h0000_0080;
        tick(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        check("fl_miss_stall", 32'(icache_stall), 32'd1);
        tick(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        check("fl_refill1", 32'(iBlkRead), 32'd1);
        tick(1'b1, 32'h0000_0080, 1'b1, 1'b0);
        check("fl_refill2", 32'(iBlkRead), 32'd1);
        tick(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        check("fl_strobe_stall", 32'(icache_stall), 32'd1);
        tick(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        check("fl_replay_stall", 32'(icache_stall), 32'd1);
        tick(1'b0, 32'h0000_0080, 1'b0, 1'b0);
        check("fl_back_idle_stall", 32'(icache_stall), 32'd0);
        check("fl_back_idle_iBlkRead", 32'(iBlkRead), 32'd0);
        fetch(32'h0000_0080, 5, 1);
        fetch(32'h0000_0040, 5, 1);

        // Flush in IDLE with a resident line: miss this cycle, no refill
        tick(1'b1, 32'h0000_0040, 1'b1, 1'b0);
        check("idle_flush_stall", 32'(icache_stall), 32'd1);
        check("idle_flush_instr1", Instr1_fIM, 32'd0);
        tick(1'b0, 32'h0000_0040, 1'b0, 1'b0);
        check("idle_flush_no_refill", 32'(iBlkRead), 32'd0);
        fetch(32'h0000_0040, 5, 1);

        // Reset while a refill is outstanding, then a stray ready pulse in IDLE
        mem_en       = 1'b0;
        exp_blk_addr = 32'h0000_0300;
        tick(1'b1, 32'h0000_0300, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0300, 1'b0, 1'b0);
        check("rr_refill", 32'(iBlkRead), 32'd1);
        fetch_req = 1'b0;
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("rr_iBlkRead_in_reset", 32'(iBlkRead), 32'd0);
        @(posedge CLK);
        #3 RESET = 1'b0;
        blk_prev = 1'b0;
        tick(1'b0, 32'h0000_0300, 1'b0, 1'b1);
        tick(1'b0, 32'h0000_0300, 1'b0, 1'b0);
        check("rr_stray_iBlkRead", 32'(iBlkRead), 32'd0);
        check("rr_stray_stall", 32'(icache_stall), 32'd0);
        mem_en = 1'b1;
        fetch(32'h0000_0300, 5, 1);
        fetch(32'h0000_0040, 5, 1);
        tick(1'b0, '0, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
